rd_empty_ctrl: RTL and testbench
================================

// Module: rd_empty_ctrl
// PURPOSE
//  Read-side controller of the dual-clock FIFO; the counterpart of the write-side full logic.
//  Synchronises the gray write pointer into r_clk and keeps the binary/gray read pointers.
//  Drives the memory read address and produces registered empty/almost_empty flags and read data.
//  Sits between the shared dual-port memory and the read-domain consumer.
// PARAMETERS
//  WIDTH     4  data word width
//  DEPTH     8  FIFO depth, power of two; AW = $clog2(DEPTH), pointers are AW+1 bits
//  AE_THRESH 1  almost_empty asserts when occupancy <= AE_THRESH (0..DEPTH-1)
// PORTS
//  r_clk        in   1        read clock
//  rst_n        in   1        asynchronous, active-low reset; one clock, reset asynchronous active-low
//  rd_rq        in   1        read request (ready in FWFT mode)
//  wptr         in   AW+1     gray write pointer from w_clk domain (asynchronous)
//  mem_rdata    in   WIDTH    memory read data, combinational from raddr
//  raddr        out  AW       memory read address = rbin[AW-1:0]
//  rptr         out  AW+1     registered gray read pointer, to write-side synchroniser
//  rdata        out  WIDTH    registered read data
//  rvalid       out  1        rdata holds valid data
//  empty        out  1        registered empty flag
//  almost_empty out  1        registered occupancy <= AE_THRESH
// BEHAVIOUR
//  Reset (async): rbin=0, rptr=0, sync regs=0, empty=1, almost_empty=1, rdata=0, rvalid=0.
//  Sync: wptr -> 2 r_clk flops -> rsync_ptr2; no other logic on the async path.
//  Pop: pop = rd_rq & ~empty; rbinnext = rbin + pop (mod 2^(AW+1)); rgraynext = rbinnext ^ (rbinnext>>1).
//  Each r_clk: rbin<=rbinnext, rptr<=rgraynext, empty<=(rgraynext==rsync_ptr2).
//  Occupancy: wbin_s = gray2bin(rsync_ptr2); cnt = wbin_s - rbinnext, AW+1 bits, modulo;
//   almost_empty <= (cnt <= AE_THRESH).
//  rd_rq while empty: ignored; pointers, raddr, rdata unchanged.
//  Wrap: bin 2^(AW+1)-1 -> 0; gray changes exactly one bit per pop; empty iff all AW+1 bits equal.
//  Latency: write visible -> empty falls 3 r_clk after wptr change (2 sync + 1 flag); flags pessimistic.
//  Pop of last word: empty rises on the same edge that advances rptr (no underflow possible).
//  Reset mid-operation: all state returns to reset values immediately; write side must reset together.
// CONFIGURATION
//  Macro RD_FWFT_EN:
//   undefined: standard mode. On pop, rdata <= mem_rdata (at current raddr) and rvalid <= 1;
//    otherwise rvalid <= 0 and rdata holds. 1-cycle read latency; rvalid is a per-pop pulse.
//   defined: first-word-fall-through. Output stage holds the head word.
//    fetch = ~empty_int & (~rvalid | rd_rq); on fetch rdata<=mem_rdata, rvalid<=1;
//    on rvalid & rd_rq & ~fetch rvalid<=0. Pointer pop = fetch.
//    Port empty = ~rvalid; rd_rq acts as ready; word accepted when rvalid & rd_rq.
//    Occupancy includes the output-stage word.
// STRUCTURE
//  Package fifo_pkg: AW function/localparam, bin2gray and gray2bin functions, ptr_t width constant;
//   shared with the write-side block.
//  Sub-module ptr_sync (2-flop, AW+1 wide, async active-low reset) instantiated once;
//   the write side reuses it for rptr.
// TESTING (DEPTH=8, WIDTH=4, AE_THRESH=1)
//  1 Reset: rst_n=0 -> empty=1, almost_empty=1, rptr=4'b0000, raddr=0, rvalid=0.
//  2 wptr 0000->0001 (one word A=4'h5) -> empty=0 on 3rd r_clk edge; rd_rq=1 -> next edge rptr=0001,
//     empty=1, rdata=5, rvalid=1 (FWFT: rdata=5 visible before rd_rq).
//  3 rd_rq held high while empty for 10 cycles -> rptr, raddr, rdata unchanged; rvalid stays 0.
//  4 Write/read 20 words continuously -> rbin wraps 15->0, rptr 1000->0000; data order preserved;
//     no false empty.
//  5 wptr=gray(3), no reads -> almost_empty=0; pop twice -> almost_empty=1 once cnt=1; pop again -> empty=1.
//  6 rst_n pulsed low mid-stream with 4 words stored -> same cycle empty=1, rptr=0, rvalid=0;
//     no X on outputs.

Source files
------------

// File: rtl/fifo_pkg.sv
// ==== fifo_pkg : pointer width helpers and gray/binary conversion shared by both FIFO sides ====
// ==== Rev 1.0 ====
`default_nettype none

package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptr_sync.sv
// ==== ptr_sync : two-flop synchroniser for a gray pointer crossing clock domains ====
// ==== Rev 1.0 ====
`default_nettype none

module ptr_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rd_empty_ctrl.sv
// ==== rd_empty_ctrl : dual-clock FIFO read side; RD_FWFT_EN selects first-word-fall-through ====
// ==== Rev 1.0 ====
`default_nettype none

module rd_empty_ctrl
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int DEPTH     = 8,
  parameter  int AE_THRESH = 1,
  localparam int AW        = addr_width(DEPTH),
  localparam int PW        = AW + 1
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic             rd_rq,
  input  logic [PW-1:0]    wptr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [AW-1:0]    raddr,
  output logic [PW-1:0]    rptr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             empty,
  output logic             almost_empty
);

  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] rsync_ptr2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] cnt;
  logic          empty_int;
  logic          pop;
  logic          rvalid_next;

  ptr_sync #(.W(PW)) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (rst_n),
    .d     (wptr),
    .q     (rsync_ptr2)
  );

  assign wbin_s    = PW'(gray2bin(ptr_t'(rsync_ptr2)));
  assign rbinnext  = rbin + PW'(pop);
  assign rgraynext = PW'(bin2gray(ptr_t'(rbinnext)));
  assign raddr     = rbin[AW-1:0];

`ifdef RD_FWFT_EN
  // The output register holds the head word; refill it whenever it is free or being consumed.
  assign pop = ~empty_int & (~rvalid | rd_rq);

  always_comb begin
    rvalid_next = rvalid;
    if (pop) begin
      rvalid_next = 1'b1;
    end else if (rvalid & rd_rq) begin
      rvalid_next = 1'b0;
    end
  end

  assign cnt   = wbin_s - rbinnext + PW'(rvalid_next);
  assign empty = ~rvalid;
`else
  assign pop         = rd_rq & ~empty_int;
  assign rvalid_next = pop;
  assign cnt         = wbin_s - rbinnext;
  assign empty       = empty_int;
`endif

  // Flags compare against the synchronised write pointer, so they can only lag toward empty.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin      <= '0;
      rptr      <= '0;
      empty_int <= 1'b1;
    end else begin
      rbin      <= rbinnext;
      rptr      <= rgraynext;
      empty_int <= (rgraynext == rsync_ptr2);
    end
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata        <= '0;
      rvalid       <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      rvalid       <= rvalid_next;
      almost_empty <= (cnt <= AE_LIMIT);
      if (pop) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rd_empty_ctrl.sv
// ==== tb_rd_empty_ctrl : self-checking bench for rd_empty_ctrl (DEPTH=8, WIDTH=4, AE_THRESH=1) ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_rd_empty_ctrl;

  logic       r_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_rq = 1'b0;
  logic [3:0] wptr  = 4'h0;
  logic [3:0] mem_rdata;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic [3:0] rdata;
  logic       rvalid;
  logic       empty;
  logic       almost_empty;

  logic [3:0] mem [8];

  int errors = 0;
  int checks = 0;

  // Write-side stand-in and reference model state
  int         wcount = 0;
  logic [3:0] data_q[$];
  int         wq[$];
  int         m_rd = 0;
  bit         m_empty = 1'b1;
  bit         m_ae = 1'b1;
  bit         m_rvalid = 1'b0;
  logic [3:0] m_rdata = 4'h0;

  typedef struct {
    bit         wr;
    logic [3:0] wd;
    bit         rd;
    bit         e_empty;
    bit         e_ae;
    bit         e_rvalid;
    logic [3:0] e_rdata;
    logic [3:0] e_rptr;
  } vec_t;

  vec_t tbl[14];

  rd_empty_ctrl #(.WIDTH(4), .DEPTH(8), .AE_THRESH(1)) dut (
    .r_clk        (r_clk),
    .rst_n        (rst_n),
    .rd_rq        (rd_rq),
    .wptr         (wptr),
    .mem_rdata    (mem_rdata),
    .raddr        (raddr),
    .rptr         (rptr),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .empty        (empty),
    .almost_empty (almost_empty)
  );

  always #5 r_clk = ~r_clk;

  assign mem_rdata = mem[raddr];

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcount = 0;
    data_q.delete();
    wq = '{0, 0};
    m_rd = 0;
    m_empty = 1'b1;
    m_ae = 1'b1;
    m_rvalid = 1'b0;
    m_rdata = 4'h0;
  endtask

  // Words become visible to the reader two edges after the write count changes.
  task automatic model_edge(input bit rd);
    int vis;
    wq.push_back(wcount);
    while (wq.size() > 3) void'(wq.pop_front());
    vis = wq[0];
    if (rd && !m_empty) begin
      m_rd++;
      m_rdata = data_q.pop_front();
      m_rvalid = 1'b1;
    end else begin
      m_rvalid = 1'b0;
    end
    m_empty = (vis == m_rd);
    m_ae = ((vis - m_rd) <= 1);
  endtask

  task automatic step(input bit wr, input logic [3:0] wd, input bit rd);
    @(negedge r_clk);
    rd_rq = rd;
    if (wr) begin
      mem[wcount % 8] = wd;
      data_q.push_back(wd);
      wcount++;
      wptr = gray4(wcount);
    end
    @(posedge r_clk);
    model_edge(rd);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'(m_empty));
    chk({tag, "_almost_empty"}, 32'(almost_empty), 32'(m_ae));
    chk({tag, "_rvalid"}, 32'(rvalid), 32'(m_rvalid));
    chk({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
    chk({tag, "_rptr"}, 32'(rptr), 32'(gray4(m_rd)));
    chk({tag, "_raddr"}, 32'(raddr), 32'(m_rd % 8));
  endtask

  task automatic release_reset();
    @(negedge r_clk);
    rst_n = 1'b1;
    @(posedge r_clk);
    model_edge(1'b0);
    #1;
  endtask

  task automatic random_steps(input int n, input string tag);
    bit wr;
    bit rd;
    for (int i = 0; i < n; i++) begin
      wr = ($urandom_range(0, 99) < 55) && ((wcount - m_rd) < 8);
      rd = ($urandom_range(0, 99) < 50);
      step(wr, 4'($urandom), rd);
      check_model(tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    model_reset();

    // Reset state
    #12;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_almost_empty", 32'(almost_empty), 32'd1);
    chk("reset_rptr", 32'(rptr), 32'd0);
    chk("reset_raddr", 32'(raddr), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    release_reset();

    // One word, then three more, drained to empty
    tbl[0]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 4'h1};
    tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 4'h1};
    tbl[5]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 4'h1};
    tbl[6]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 4'h1};
    tbl[7]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 4'h1};
    tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h1};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h1};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 4'h3};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 4'h2};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 4'h6};
    tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h6};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd);
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d_almost_empty", i), 32'(almost_empty), 32'(tbl[i].e_ae));
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].e_rvalid));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].e_rdata));
      chk($sformatf("vec%0d_rptr", i), 32'(rptr), 32'(tbl[i].e_rptr));
    end

    // Reads requested while empty are ignored
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'h0, 1'b1);
      chk("idle_rd_rptr", 32'(rptr), 32'h6);
      chk("idle_rd_raddr", 32'(raddr), 32'h4);
      chk("idle_rd_rdata", 32'(rdata), 32'h3);
      chk("idle_rd_rvalid", 32'(rvalid), 32'd0);
      chk("idle_rd_empty", 32'(empty), 32'd1);
    end

    // Continuous streaming through pointer wrap
    for (int i = 0; i < 30; i++) begin
      step((wcount - m_rd) < 8, 4'(i + 7), 1'b1);
      check_model("stream");
    end

    random_steps(400, "rand");

    // Reset while four words are stored
    while (!m_empty) begin
      step(1'b0, 4'h0, 1'b1);
      check_model("drain");
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(4'hA + i), 1'b0);
      check_model("prefill");
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 1'b0);
      check_model("prefill_wait");
    end
    @(negedge r_clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_almost_empty", 32'(almost_empty), 32'd1);
    chk("midrst_rptr", 32'(rptr), 32'd0);
    chk("midrst_raddr", 32'(raddr), 32'd0);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    chk("midrst_no_x", 32'($isunknown({raddr, rptr, rdata, rvalid, empty, almost_empty})), 32'd0);
    model_reset();
    wptr = 4'h0;
    rd_rq = 1'b0;
    release_reset();
    check_model("post_rst");

    random_steps(60, "rand2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
